// File: rtl/cbi980_i2s_tx_if.sv
// Register port of the CBI980 I2S transmitter.
// Master drives strobes/addresses, slave returns read data.
interface cbi980_i2s_tx_if;
   logic        write_en;
   logic [31:0] write_addr;
   logic [31:0] write_data;
   logic        read_en;
   logic [31:0] read_addr;
   logic [31:0] read_data;
   logic        read_vld;

   modport master (
      output write_en, write_addr, write_data,
      output read_en, read_addr,
      input  read_data, read_vld
   );

   modport slave (
      input  write_en, write_addr, write_data,
      input  read_en, read_addr,
      output read_data, read_vld
   );
endinterface

// File: rtl/cbi980_i2s_tx.sv
// CBI980 I2S transmitter: registers, sample FIFO, frame sequencer.
// Optional low-water irq and CTRL.IRQ_MASK under CBI980_TX_IRQ_EN.
module cbi980_i2s_tx #(
   parameter int DEPTH = 8,
   parameter int DIV_W = 8
) (
   input  logic           aclk,
   input  logic           arstn,
   cbi980_i2s_tx_if.slave bus,
   output logic           i2s_bclk,
   output logic           i2s_lrclk,
   output logic           i2s_sdata,
   output logic           irq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic             en;
   logic             mask;
   logic [DIV_W-1:0] clkdiv;
   logic [DIV_W-1:0] div_act;
   logic [DIV_W-1:0] div;
   logic [4:0]       slot;
   logic [31:0]      shreg;
   logic             underrun;
   logic             overflow;
   logic [31:0]      mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    level;

   logic [1:0]  wsel;
   logic [1:0]  rsel;
   logic        wr_ctrl;
   logic        wr_div;
   logic        wr_stat;
   logic        wr_tx;
   logic        flush;
   logic        en_nxt;
   logic        empty;
   logic        full;
   logic        fall;
   logic        load;
   logic        pop;
   logic        push;
   logic        und_set;
   logic        ovf_set;
   logic [4:0]  slot_nxt;
   logic [31:0] word;
   logic [31:0] rd_mux;
   logic        unused_bits;

   assign wsel     = bus.write_addr[3:2];
   assign rsel     = bus.read_addr[3:2];
   assign wr_ctrl  = bus.write_en && wsel == 2'd0;
   assign wr_div   = bus.write_en && wsel == 2'd1;
   assign wr_stat  = bus.write_en && wsel == 2'd2;
   assign wr_tx    = bus.write_en && wsel == 2'd3;
   assign flush    = wr_ctrl && bus.write_data[1];
   assign en_nxt   = wr_ctrl ? bus.write_data[0] : en;
   assign empty    = level == '0;
   assign full     = level == CW'(DEPTH);
   assign slot_nxt = slot + 5'd1;

   // Falling bclk edge; a pending EN=0 write pre-empts it.
   assign fall    = state == RUN && en_nxt &&
                    div == div_act && i2s_bclk;
   assign load    = fall && slot_nxt == 5'd1;
   assign pop     = load && !empty;
   assign und_set = load && empty;
   assign push    = wr_tx && (!full || pop);
   assign ovf_set = wr_tx && full && !pop;
   assign word    = empty ? '0 : mem[rptr];

   assign unused_bits = ^{bus.write_addr[31:4],
                          bus.write_addr[1:0],
                          bus.read_addr[31:4],
                          bus.read_addr[1:0]};

   always_ff @(posedge aclk) begin
      if (push) mem[wptr] <= bus.write_data;
   end

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         en       <= 1'b0;
         clkdiv   <= DIV_W'(3);
         underrun <= 1'b0;
         overflow <= 1'b0;
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
      end else begin
         if (wr_ctrl) en <= bus.write_data[0];
         if (wr_div) clkdiv <= bus.write_data[DIV_W-1:0];
         if (und_set) underrun <= 1'b1;
         else if (wr_stat && bus.write_data[2]) underrun <= 1'b0;
         if (ovf_set) overflow <= 1'b1;
         else if (wr_stat && bus.write_data[3]) overflow <= 1'b0;
         if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
         end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            level <= level + CW'(push) - CW'(pop);
         end
      end
   end

`ifdef CBI980_TX_IRQ_EN
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         mask <= 1'b0;
         irq  <= 1'b0;
      end else begin
         if (wr_ctrl) mask <= bus.write_data[2];
         irq <= en && level <= CW'(DEPTH / 2) && !mask;
      end
   end
`else
   assign mask = 1'b0;
   assign irq  = 1'b0;
`endif

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state     <= IDLE;
         div       <= '0;
         div_act   <= '0;
         slot      <= '0;
         shreg     <= '0;
         i2s_bclk  <= 1'b0;
         i2s_lrclk <= 1'b0;
         i2s_sdata <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               div_act <= clkdiv;
               if (en_nxt) state <= RUN;
            end
            RUN: begin
               if (!en_nxt) begin
                  state     <= IDLE;
                  div       <= '0;
                  slot      <= '0;
                  shreg     <= '0;
                  i2s_bclk  <= 1'b0;
                  i2s_lrclk <= 1'b0;
                  i2s_sdata <= 1'b0;
               end else if (div == div_act) begin
                  div      <= '0;
                  div_act  <= clkdiv;
                  i2s_bclk <= !i2s_bclk;
                  if (i2s_bclk) begin
                     slot      <= slot_nxt;
                     i2s_lrclk <= slot_nxt[4];
                     // Shifted-out zeros leave R bit 0 for slot 0.
                     if (load) begin
                        i2s_sdata <= word[31];
                        shreg     <= {word[30:0], 1'b0};
                     end else begin
                        i2s_sdata <= shreg[31];
                        shreg     <= {shreg[30:0], 1'b0};
                     end
                  end
               end else begin
                  div <= div + DIV_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      unique case (rsel)
         2'd0: rd_mux[2:0] = {mask, 1'b0, en};
         2'd1: rd_mux[DIV_W-1:0] = clkdiv;
         2'd2: begin
            rd_mux[3:0]     = {overflow, underrun, full, empty};
            rd_mux[8 +: CW] = level;
         end
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         bus.read_data <= '0;
         bus.read_vld  <= 1'b0;
      end else begin
         bus.read_vld <= bus.read_en;
         if (bus.read_en) bus.read_data <= rd_mux;
      end
   end
endmodule

// File: tb/tb_cbi980_i2s_tx.sv
// Directed bench for cbi980_i2s_tx with a serial-slot scoreboard.
// Define CBI980_TX_IRQ_EN to also exercise the irq path.
module tb_cbi980_i2s_tx;
   localparam int DEPTH = 8;
   localparam logic [31:0] A_CTRL = 32'h0000_0000;
   localparam logic [31:0] A_DIV  = 32'h0000_0004;
   localparam logic [31:0] A_STAT = 32'h4000_0008;
   localparam logic [31:0] A_TX   = 32'h0000_000C;

   logic aclk = 1'b0;
   logic arstn;
   logic bclk, lrclk, sdata, irq;
   int   checks = 0;
   int   errors = 0;
   logic [1:0] exp_q [$];

   always #5 aclk = ~aclk;

   cbi980_i2s_tx_if bus ();

   cbi980_i2s_tx #(.DEPTH(DEPTH), .DIV_W(8)) dut (
      .aclk      (aclk),
      .arstn     (arstn),
      .bus       (bus),
      .i2s_bclk  (bclk),
      .i2s_lrclk (lrclk),
      .i2s_sdata (sdata),
      .irq       (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.write_en   = 1'b1;
      bus.write_addr = a;
      bus.write_data = d;
      step();
      bus.write_en = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
      bus.read_en   = 1'b1;
      bus.read_addr = a;
      step();
      bus.read_en = 1'b0;
      chk({tag, "_vld"}, {31'b0, bus.read_vld}, 32'd1);
      chk(tag, bus.read_data, exp);
   endtask

   task automatic wait_fall();
      int n = 0;
      while (bclk !== 1'b1 && n < 4000) begin step(); n++; end
      while (bclk !== 1'b0 && n < 4000) begin step(); n++; end
      chk("fall_timeout", {31'b0, n < 4000}, 32'd1);
   endtask

   task automatic push_frame(input logic [31:0] w);
      for (int k = 1; k < 32; k++)
         exp_q.push_back({k >= 16, w[32-k]});
      exp_q.push_back({1'b0, w[0]});
   endtask

   task automatic slot_chk(input string tag);
      logic [1:0] e;
      wait_fall();
      chk("sb_empty", {31'b0, exp_q.size() != 0}, 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b00;
      chk(tag, {30'b0, lrclk, sdata}, {30'b0, e});
   endtask

   initial begin
      longint t0;
      logic [1:0] e;
      arstn = 1'b0;
      bus.write_en = 1'b0;
      bus.write_addr = '0;
      bus.write_data = '0;
      bus.read_en = 1'b0;
      bus.read_addr = '0;
      step(3);
      chk("rst_pins", {28'b0, bclk, lrclk, sdata, irq}, 32'd0);
      chk("rst_rvld", {31'b0, bus.read_vld}, 32'd0);
      chk("rst_rdata", bus.read_data, 32'd0);
      arstn = 1'b1;
      step();
      rdchk("rst_ctrl", A_CTRL, 32'h0);
      rdchk("rst_div", A_DIV, 32'h3);
      rdchk("rst_stat", A_STAT, 32'h1);
      rdchk("rst_tx", A_TX, 32'h0);

      // one frame at CLKDIV=0
      wr(A_DIV, 32'h0);
      wr(A_TX, 32'hA5A5_3C3C);
      push_frame(32'hA5A5_3C3C);
      wr(A_CTRL, 32'h1);
      chk("entry_bclk", {31'b0, bclk}, 32'd0);
      chk("entry_sdata", {31'b0, sdata}, 32'd0);
      step();
      chk("first_rise", {31'b0, bclk}, 32'd1);
      slot_chk("slot_a5");
      t0 = $time;
      for (int i = 0; i < 31; i++) slot_chk("slot_a5");
      chk("frame_time", 32'($time - t0), 32'd620);
      rdchk("empty_pop", A_STAT, 32'h1);
      wr(A_CTRL, 32'h0);
      rdchk("stat_stop", A_STAT, 32'h1);

      // underrun, W1C, W1C racing a new underrun
      wr(A_DIV, 32'h3);
      push_frame(32'h0);
      wr(A_CTRL, 32'h1);
      slot_chk("slot_udr");
      rdchk("udr_set", A_STAT, 32'h5);
      wr(A_STAT, 32'h4);
      rdchk("udr_w1c", A_STAT, 32'h1);
      for (int i = 0; i < 31; i++) slot_chk("slot_udr");
      step(7);
      wr(A_STAT, 32'h4);
      chk("race_bclk", {31'b0, bclk}, 32'd0);
      chk("race_sdata", {31'b0, sdata}, 32'd0);
      rdchk("udr_race", A_STAT, 32'h5);
      wr(A_STAT, 32'h4);
      rdchk("udr_clr", A_STAT, 32'h1);
      wr(A_CTRL, 32'h0);

      // overflow and flush
      wr(A_STAT, 32'hC);
      rdchk("stat_clean", A_STAT, 32'h1);
      for (int i = 0; i <= DEPTH; i++) wr(A_TX, 32'(i));
      rdchk("full_ovf", A_STAT, 32'h80A);
      bus.write_en = 1'b1;
      bus.write_addr = A_STAT;
      bus.write_data = 32'h8;
      bus.read_en = 1'b1;
      bus.read_addr = A_STAT;
      step();
      bus.write_en = 1'b0;
      bus.read_en = 1'b0;
      chk("rw_same", bus.read_data, 32'h80A);
      rdchk("ovf_clr", A_STAT, 32'h802);
      wr(A_CTRL, 32'h2);
      rdchk("flush_stat", A_STAT, 32'h1);
      rdchk("flush_ctrl", A_CTRL, 32'h0);

      // disable at slot 10, then restart
      wr(A_DIV, 32'h1);
      wr(A_TX, 32'hFFFF_8001);
      wr(A_TX, 32'hCAFE_F00D);
      wr(A_TX, 32'h1357_2468);
      push_frame(32'hFFFF_8001);
      wr(A_CTRL, 32'h1);
      for (int i = 0; i < 10; i++) slot_chk("slot_w1");
      step(2);
      chk("pre_dis", {30'b0, bclk, sdata}, 32'd3);
      wr(A_CTRL, 32'h0);
      chk("dis_pins", {29'b0, bclk, lrclk, sdata}, 32'd0);
      exp_q.delete();
      rdchk("dis_level", A_STAT, 32'h200);
      wr(A_CTRL, 32'h1);
      chk("re_slot0", {29'b0, bclk, lrclk, sdata}, 32'd0);
      e = {1'b0, 1'b1};
      exp_q.push_back(e);
      slot_chk("re_slot1");
      wr(A_CTRL, 32'h0);
      rdchk("re_level", A_STAT, 32'h100);

`ifdef CBI980_TX_IRQ_EN
      wr(A_CTRL, 32'h2);
      wr(A_DIV, 32'hFF);
      wr(A_CTRL, 32'h1);
      for (int i = 0; i < 5; i++) wr(A_TX, 32'(i));
      step(2);
      chk("irq_lvl5", {31'b0, irq}, 32'd0);
      wait_fall();
      step(2);
      chk("irq_lvl4", {31'b0, irq}, 32'd1);
      wr(A_CTRL, 32'h5);
      step();
      chk("irq_mask", {31'b0, irq}, 32'd0);
      wr(A_CTRL, 32'h2);
      wr(A_DIV, 32'h1);
`else
      wr(A_CTRL, 32'h2);
      wr(A_CTRL, 32'h5);
      step(2);
      chk("irq_off", {31'b0, irq}, 32'd0);
      rdchk("mask_ro", A_CTRL, 32'h1);
      wr(A_CTRL, 32'h0);
`endif

      // asynchronous reset mid-frame
      wr(A_TX, 32'h0000_0001);
      wr(A_CTRL, 32'h1);
      step(2);
      chk("pre_rst_bclk", {31'b0, bclk}, 32'd1);
      #2 arstn = 1'b0;
      #1;
      chk("arst_pins", {28'b0, bclk, lrclk, sdata, irq}, 32'd0);
      step();
      arstn = 1'b1;
      step();
      rdchk("arst_stat", A_STAT, 32'h1);
      rdchk("arst_div", A_DIV, 32'h3);
      rdchk("arst_ctrl", A_CTRL, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
